// File: rtl/if_id_queue.sv
// IF/ID decoupling FIFO between the fetch unit and the decoder, with a NOP on empty.
// Define IF_ID_Q_BYPASS_EN to let an instruction fetched into an empty queue reach decode in the same cycle.
module if_id_queue #(
    parameter int unsigned        DEPTH   = 4,
    parameter int unsigned        ADDR_W  = 32,
    parameter int unsigned        INS_W   = 32,
    parameter logic [INS_W-1:0]   NOP_INS = 32'h00000013
) (
    input  logic                         clk_i,
    input  logic                         n_rst_i,
    input  logic                         flush_i,
    input  logic                         branch_redirect_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [ADDR_W-1:0]            pc_i,
    input  logic [INS_W-1:0]             ins_i,
    input  logic [ADDR_W-1:0]            next_pc_i,
    input  logic                         next_taken_i,
    input  logic                         branch_slot_end_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [ADDR_W-1:0]            pc_o,
    output logic [INS_W-1:0]             ins_o,
    output logic [ADDR_W-1:0]            next_pc_o,
    output logic                         next_taken_o,
    output logic                         branch_slot_end_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INS_W-1:0]  ins_mem  [DEPTH];
    logic [ADDR_W-1:0] npc_mem  [DEPTH];
    logic              tk_mem   [DEPTH];
    logic              se_mem   [DEPTH];

    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [ADDR_W-1:0] last_pc;
    logic [ADDR_W-1:0] last_npc;

    logic flush;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    assign flush = flush_i | branch_redirect_i;
    assign empty = (count == '0);

`ifdef IF_ID_Q_BYPASS_EN
    assign bypass = empty & valid_i & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign ready_o = (count < CW'(DEPTH));
    assign valid_o = ~empty | bypass;
    assign count_o = count;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    // A bypassed instruction that is consumed immediately never touches storage;
    // bypass only happens when empty, so it never pops storage either.
    assign wr_en = push & ~flush & ~(bypass & ready_i);
    assign rd_en = pop & ~flush & ~bypass;

    always_comb begin
        count_nxt = count;
        if (wr_en && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        pc_o              = last_pc;
        ins_o             = NOP_INS;
        next_pc_o         = last_npc;
        next_taken_o      = 1'b0;
        branch_slot_end_o = 1'b0;
        if (bypass) begin
            pc_o              = pc_i;
            ins_o             = ins_i;
            next_pc_o         = next_pc_i;
            next_taken_o      = next_taken_i;
            branch_slot_end_o = branch_slot_end_i;
        end else if (!empty) begin
            pc_o              = pc_mem[rd_ptr];
            ins_o             = ins_mem[rd_ptr];
            next_pc_o         = npc_mem[rd_ptr];
            next_taken_o      = tk_mem[rd_ptr];
            branch_slot_end_o = se_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            last_pc  <= '0;
            last_npc <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Remember the consumed pc so a bubble still presents a stable pc.
            if (pop) begin
                last_pc  <= pc_o;
                last_npc <= next_pc_o;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            pc_mem[wr_ptr]  <= pc_i;
            ins_mem[wr_ptr] <= ins_i;
            npc_mem[wr_ptr] <= next_pc_i;
            tk_mem[wr_ptr]  <= next_taken_i;
            se_mem[wr_ptr]  <= branch_slot_end_i;
        end
    end

endmodule
